inst_issue: RTL and testbench
=============================

# inst_issue

Instruction fetch/issue stage feeding the combinational instruction decoder. On a start command it streams a program of 32-bit instruction words from the synchronous instruction memory, starting at a given address, into a small prefetch FIFO. It then presents them one at a time on a valid/ready interface: `inst` drives the decoder, and `inst_ready` comes from the dispatcher that knows whether the target ldst/mover/exec unit can accept the command.

## Interface

Parameters:
- `IMEM_ADDR_W`, default 10: instruction memory word-address width; also the width of the program length.
- `FIFO_DEPTH`, default 4: prefetch FIFO entries; must be a power of 2 and at least 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `abort`  in  1  flush and return to IDLE; highest priority.
- `start_pc`  in  IMEM_ADDR_W  word address of the first instruction; sampled with `start`.
- `prog_len`  in  IMEM_ADDR_W  number of instructions to issue; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the last instruction is accepted downstream.
- `imem_rd`  out  1  read strobe to instruction memory.
- `imem_addr`  out  IMEM_ADDR_W  read address.
- `imem_rdata`  in  32  read data, valid the cycle after `imem_rd`.
- `inst`  out  32  FIFO head instruction, to the decoder; 0 when the FIFO is empty.
- `inst_pc`  out  IMEM_ADDR_W  address of the head instruction; 0 when the FIFO is empty.
- `inst_valid`  out  1  head is valid.
- `inst_ready`  in  1  downstream accepts the head.

## Operation

- States are IDLE and RUN.
- **IDLE**
  - `start` with `prog_len` != 0: latch `fetch_pc` = `start_pc`, `fetch_left` = `issue_left` = `prog_len`, and go to RUN.
  - `start` with `prog_len` == 0: pulse `done` in the next cycle and stay in IDLE.
- **RUN, fetch side**
  - `imem_rd` = RUN && `fetch_left` != 0 && (`occupancy` + `inflight`) < `FIFO_DEPTH`.
  - `inflight` is 1 if `imem_rd` was high in the previous cycle.
  - `imem_addr` = `fetch_pc`. On each read, `fetch_pc` increments modulo 2^`IMEM_ADDR_W` (wrap from all-ones to 0 is legal) and `fetch_left` decrements.
  - A returning word is pushed together with its address. The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error.
- **RUN, issue side**
  - `inst_valid` = FIFO not empty. A pop occurs when `inst_valid` && `inst_ready`, and decrements `issue_left`.
  - While `inst_valid` && !`inst_ready`, `inst`, `inst_pc` and `inst_valid` hold stable.
  - A simultaneous push and pop leaves `occupancy` unchanged.
- **Completion:** the pop that brings `issue_left` to 0 registers `done`, which is high for exactly the next cycle. The state moves to IDLE on the same edge.
- **Start while busy:** `start` during RUN is ignored, including in the completion cycle.
- **Abort**
  - `abort` in RUN clears the FIFO and the counters and goes to IDLE on that edge; no `done` is produced.
  - A read issued in the abort cycle, or still in flight, returns data that is discarded and never pushed.
  - `abort` in IDLE has no effect. `abort` and `start` in the same cycle: abort wins and start is ignored.
- **Reset (asynchronous):** state IDLE, FIFO empty, all counters 0, `busy`=0, `done`=0, `imem_rd`=0, `imem_addr`=0, `inst`=0, `inst_pc`=0, `inst_valid`=0.

## Timing

- `start` high in cycle 0 → RUN and `busy` high in cycle 1 → `imem_rd` high in cycle 1 with `imem_addr`=`start_pc` → `imem_rdata` valid in cycle 2 → `inst_valid` high in cycle 3 with that word.
- Start-to-first-valid latency is 3 cycles.
- With `inst_ready` held high, throughput is 1 instruction per cycle: one read per cycle, no bubbles after the first.
- Last pop in cycle N → `done`=1 in cycle N+1, `busy`=0 in cycle N+1, `inst_valid`=0 in cycle N+1.
- `abort` in cycle N → `inst_valid`=0, `busy`=0, `imem_rd`=0 from cycle N+1.
- All outputs are driven from registers or from state and FIFO registers only. No combinational path exists from `inst_ready` to `imem_rd`, except through the credit count's registered occupancy.

## Test plan

- **Streaming:** `start_pc`=0x010, `prog_len`=5, `inst_ready`=1, memory word = 0xA000_0000 | address.
  - Required: `inst` = 0xA000_0010 through 0xA000_0014 on cycles 3 to 7.
  - Required: `done` in cycle 8; exactly 5 `imem_rd` pulses.
- **Backpressure:** `prog_len`=8 with `inst_ready`=0 for cycles 0–15.
  - Required: `imem_rd` stops after 4 reads and `inst` holds 0xA000_0010 stable.
  - Releasing `inst_ready`: all 8 words are issued in order with no loss or duplication.
- **Address wrap:** `start_pc`=0x3FE, `prog_len`=4.
  - Required: `imem_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001, and `inst_pc` matches.
- **Zero length:** `prog_len`=0.
  - Required: `done`=1 in cycle 1, `busy` never high, no `imem_rd`.
- **Abort mid-run:** `abort` while a read is in flight and the FIFO has 2 entries.
  - Required: next cycle `inst_valid`=0, the in-flight word is not issued, and no `done`.
  - A following `start` fetches cleanly from its new `start_pc`.
- **Reset and start while busy:** assert `rst` mid-run.
  - Required: all outputs are at their reset values immediately (asynchronous).
  - Separately, a `start` pulse during RUN does not change `fetch_pc` or `prog_len`.

Source files
------------

// File: rtl/inst_issue.sv
// Instruction fetch/issue stage: streams a program from synchronous instruction
// memory through a small prefetch FIFO and hands words out on a valid/ready port.
module inst_issue #(
  parameter int IMEM_ADDR_W = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [IMEM_ADDR_W-1:0] start_pc,
  input  logic [IMEM_ADDR_W-1:0] prog_len,
  output logic                   busy,
  output logic                   done,
  output logic                   imem_rd,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            inst,
  output logic [IMEM_ADDR_W-1:0] inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [IMEM_ADDR_W-1:0] ONE_A   = IMEM_ADDR_W'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [IMEM_ADDR_W-1:0] fetch_pc_reg;
  logic [IMEM_ADDR_W-1:0] fetch_left_reg;
  logic [IMEM_ADDR_W-1:0] issue_left_reg;
  logic [IMEM_ADDR_W-1:0] inflight_pc_reg;
  logic                   inflight_reg;
  logic                   done_reg;
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       credit_used;

  logic [31:0]            data_mem [FIFO_DEPTH];
  logic [IMEM_ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

  logic run_ok, push_en, pop, last_pop, start_ok;

  // Words already in the FIFO plus the one still returning from memory.
  assign credit_used = count_reg + CNT_W'(inflight_reg);

  assign run_ok     = (state_reg == RUN) && !abort;
  assign start_ok   = (state_reg == IDLE) && start && !abort;
  assign inst_valid = (count_reg != '0);
  assign pop        = inst_valid && inst_ready;
  assign push_en    = inflight_reg && run_ok;
  assign last_pop   = pop && (issue_left_reg == ONE_A);

  assign imem_rd    = (state_reg == RUN) && (fetch_left_reg != '0) && (credit_used < DEPTH_C);
  assign imem_addr  = fetch_pc_reg;
  assign busy       = (state_reg == RUN);
  assign done       = done_reg;
  assign inst       = inst_valid ? data_mem[rd_ptr_reg] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok && prog_len != '0) state_next = RUN;
      RUN:     if (abort || last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= '0;
      fetch_left_reg  <= '0;
      issue_left_reg  <= '0;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
      done_reg        <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        inflight_reg <= 1'b0;
        if (start_ok) begin
          if (prog_len == '0) begin
            done_reg <= 1'b1;
          end else begin
            fetch_pc_reg   <= start_pc;
            fetch_left_reg <= prog_len;
            issue_left_reg <= prog_len;
          end
        end
      end else if (abort) begin
        // Clearing inflight drops any word still on its way back from memory.
        fetch_pc_reg   <= '0;
        fetch_left_reg <= '0;
        issue_left_reg <= '0;
        inflight_reg   <= 1'b0;
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        count_reg      <= '0;
      end else begin
        inflight_reg <= imem_rd;
        if (imem_rd) begin
          fetch_pc_reg    <= fetch_pc_reg + ONE_A;
          fetch_left_reg  <= fetch_left_reg - ONE_A;
          inflight_pc_reg <= fetch_pc_reg;
        end
        if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop) begin
          rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
          issue_left_reg <= issue_left_reg - ONE_A;
        end
        case ({push_en, pop})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
        if (last_pop) done_reg <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted in count_reg.
  always_ff @(posedge clk) begin
    if (push_en) begin
      data_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
    end
  end

endmodule

// File: tb/tb_inst_issue.sv
// Randomized bench for inst_issue: each program run is scored against the
// expected issue order, handshake rules and completion/abort behaviour.
module tb_inst_issue;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [AW-1:0] prog_len = '0;
  logic          busy, done, imem_rd, inst_valid;
  logic          inst_ready = 1'b0;
  logic [AW-1:0] imem_addr, inst_pc;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   inst;

  int checks   = 0;
  int failures = 0;

  inst_issue #(.IMEM_ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .start_pc   (start_pc),
    .prog_len   (prog_len),
    .busy       (busy),
    .done       (done),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word content is 0xA000_0000 | address.
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= 32'hA000_0000 | 32'(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_rd"},    32'(imem_rd), 0);
    check({tag, "_addr"},  32'(imem_addr), 0);
    check({tag, "_inst"},  inst, 0);
    check({tag, "_pc"},    32'(inst_pc), 0);
    check({tag, "_valid"}, 32'(inst_valid), 0);
  endtask

  function automatic logic next_ready(input int c, input int hold_low, input int abort_cyc,
                                      input int ready_pct);
    if (c < hold_low || c == abort_cyc) return 1'b0;
    return ($urandom_range(99) < ready_pct);
  endfunction

  // Runs one program from IDLE; caller is positioned just after a rising edge.
  task automatic run_prog(input logic [AW-1:0] pc, input int len, input int ready_pct,
                          input int hold_low, input int abort_cyc, input int extra_start);
    logic [AW-1:0] exp_pc[$];
    logic [31:0]   prev_inst;
    logic [AW-1:0] prev_pc;
    int  c, nrd, npop, idle_cnt, budget;
    bit  busy_exp, done_exp, busy_nx, done_nx, hs, hold_pend, full, finished, ab_now;

    for (int i = 0; i < len; i++) exp_pc.push_back(AW'(pc + i));
    full = (ready_pct >= 100) && (hold_low == 0) && (abort_cyc < 0);
    c = 0; nrd = 0; npop = 0; idle_cnt = 0; budget = 40 * len + 60;
    busy_exp = 0; done_exp = 0; hold_pend = 0; finished = 0;
    prev_inst = '0; prev_pc = '0;

    start = 1'b1; start_pc = pc; prog_len = AW'(len); abort = 1'b0;
    inst_ready = next_ready(0, hold_low, abort_cyc, ready_pct);

    while (!finished && c < budget) begin
      @(negedge clk);
      ab_now = abort;
      check("busy", 32'(busy), 32'(busy_exp));
      check("done", 32'(done), 32'(done_exp));
      if (!busy_exp) begin
        check("idle_rd", 32'(imem_rd), 0);
        check("idle_valid", 32'(inst_valid), 0);
      end
      if (!inst_valid) begin
        check("empty_inst", inst, 0);
        check("empty_pc", 32'(inst_pc), 0);
      end
      if (hold_pend) begin
        check("hold_valid", 32'(inst_valid), 1);
        check("hold_inst", inst, prev_inst);
        check("hold_pc", 32'(inst_pc), 32'(prev_pc));
      end
      if (full) begin
        check("rd_slot", 32'(imem_rd), 32'(c >= 1 && c <= len));
        check("valid_slot", 32'(inst_valid), 32'(c >= 3 && c < 3 + len));
      end
      if (hold_low > 6 && abort_cyc < 0 && c == hold_low - 1) begin
        check("bp_reads", 32'(nrd), 32'((len < DEPTH) ? len : DEPTH));
        check("bp_head", inst, 32'hA000_0000 | 32'(pc));
      end
      if (imem_rd) begin
        check("imem_addr", 32'(imem_addr), 32'(AW'(pc + nrd)));
        check("credit", 32'((nrd - npop) < DEPTH), 1);
        check("rd_bound", 32'(nrd < len), 1);
        nrd++;
      end
      hs = inst_valid && inst_ready;
      if (hs) begin
        if (npop < len) begin
          check("inst", inst, 32'hA000_0000 | 32'(exp_pc[npop]));
          check("inst_pc", 32'(inst_pc), 32'(exp_pc[npop]));
        end else begin
          check("extra_pop", 32'(npop), 32'(len));
        end
        npop++;
      end

      done_nx = 0;
      if (c == 0) begin
        busy_nx = (len != 0);
        done_nx = (len == 0);
      end else begin
        busy_nx = busy_exp;
        if (busy_exp && ab_now) busy_nx = 0;
        else if (busy_exp && hs && npop == len) begin
          busy_nx = 0;
          done_nx = 1;
        end
      end
      hold_pend = inst_valid && !inst_ready && !ab_now;
      prev_inst = inst;
      prev_pc   = inst_pc;
      if (c > 0 && !busy_nx) idle_cnt++;
      finished = (idle_cnt > 3);
      busy_exp = busy_nx;
      done_exp = done_nx;

      @(posedge clk); #1;
      c++;
      start = (c == extra_start);
      if (start) begin
        start_pc = AW'($urandom_range(1023));
        prog_len = AW'($urandom_range(1, 50));
      end
      abort = (c == abort_cyc);
      inst_ready = next_ready(c, hold_low, abort_cyc, ready_pct);
    end
    start = 1'b0;
    abort = 1'b0;
    check("finished", 32'(finished), 1);
    if (abort_cyc < 0) begin
      check("issued", 32'(npop), 32'(len));
      check("reads", 32'(nrd), 32'(len));
    end
    $display("run pc=%h len=%0d ready=%0d%% hold=%0d abort=%0d xstart=%0d reads=%0d issued=%0d cycles=%0d",
             pc, len, ready_pct, hold_low, abort_cyc, extra_start, nrd, npop, c);
  endtask

  initial begin
    int len, rp, hl, ab;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    run_prog(10'h010, 5, 100, 0, -1, -1);   // streaming
    run_prog(10'h010, 8, 100, 16, -1, -1);  // backpressure
    run_prog(10'h3FE, 4, 100, 0, -1, -1);   // address wrap
    run_prog(10'h123, 0, 100, 0, -1, -1);   // zero length
    run_prog(10'h100, 8, 100, 100, 4, -1);  // abort with 2 queued + 1 in flight
    run_prog(10'h200, 3, 100, 0, -1, -1);   // clean restart after abort
    run_prog(10'h040, 6, 100, 0, -1, 4);    // start while busy
    run_prog(10'h060, 5, 100, 0, -1, 7);    // start in completion cycle

    for (int k = 0; k < 10; k++) begin
      len = $urandom_range(1, 20);
      rp  = $urandom_range(20, 100);
      hl  = ($urandom_range(1) == 1) ? 8 : 0;
      ab  = (k % 4 == 3) ? $urandom_range(2, len + 1) : -1;
      run_prog(AW'($urandom_range(1023)), len, rp, hl, ab, -1);
    end

    // Asynchronous reset in the middle of a run
    start = 1'b1; start_pc = 10'h050; prog_len = 10'd8; inst_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("post_rst");
    run_prog(10'h070, 3, 100, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
